// File: rtl/vx_mem_responder_if.sv
// Request/response bundle of the core memory bus between a requester (master) and a memory endpoint (slave).
// The master drives the request fields and rsp_ready; the slave drives req_ready and the response fields.
interface vx_mem_responder_if #(
    parameter int DATA_SIZE  = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int TAG_WIDTH  = 8
);
    logic                    req_valid;
    logic                    req_rw;
    logic [DATA_SIZE-1:0]    req_byteen;
    logic [ADDR_WIDTH-1:0]   req_addr;
    logic [8*DATA_SIZE-1:0]  req_data;
    logic [TAG_WIDTH-1:0]    req_tag;
    logic                    req_ready;

    logic                    rsp_valid;
    logic [8*DATA_SIZE-1:0]  rsp_data;
    logic [TAG_WIDTH-1:0]    rsp_tag;
    logic                    rsp_ready;

    modport master (
        output req_valid, req_rw, req_byteen, req_addr, req_data, req_tag, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_tag
    );

    modport slave (
        input  req_valid, req_rw, req_byteen, req_addr, req_data, req_tag, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_tag
    );
endinterface

// File: rtl/vx_mem_responder.sv
// Word-addressed scratchpad answering tagged reads, in order, through a LATENCY-deep pipeline and a show-ahead FIFO.
// Credits gate req_ready so rsp backpressure never overflows the FIFO; define MEM_RSP_WRITE_ACK_EN to also ack writes.
module vx_mem_responder #(
    parameter int DATA_SIZE  = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int TAG_WIDTH  = 8,
    parameter int MEM_WORDS  = 1024,
    parameter int LATENCY    = 2,
    parameter int RSP_DEPTH  = 4
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    vx_mem_responder_if.slave  bus
);
    localparam int DW = 8 * DATA_SIZE;
    localparam int IW = $clog2(MEM_WORDS);
    localparam int CW = $clog2(RSP_DEPTH + 1);
    localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;

    logic [CW-1:0]        credits_q, credits_d;
    logic [CW-1:0]        count_q;
    logic [PW-1:0]        wr_ptr_q, rd_ptr_q;
    logic                 req_fire, rsp_fire, rsp_prod;
    logic [IW-1:0]        idx;
    logic [DW-1:0]        mem_q [MEM_WORDS];
    logic [DW-1:0]        rd_dat;
    logic                 push_vld;
    logic [DW-1:0]        push_dat;
    logic [TAG_WIDTH-1:0] push_tag;
    logic [DW-1:0]        fifo_dat_q [RSP_DEPTH];
    logic [TAG_WIDTH-1:0] fifo_tag_q [RSP_DEPTH];

    // Upper address bits alias onto the array.
    assign idx = bus.req_addr[IW-1:0];
    if (ADDR_WIDTH > IW) begin : g_unused
        logic unused_addr_bits;
        assign unused_addr_bits = ^bus.req_addr[ADDR_WIDTH-1:IW];
    end

    assign bus.req_ready = rst_ni && (credits_q != '0);
    assign req_fire      = bus.req_valid && bus.req_ready;
    assign rsp_fire      = bus.rsp_valid && bus.rsp_ready;

`ifdef MEM_RSP_WRITE_ACK_EN
    assign rsp_prod = req_fire;
    assign rd_dat   = bus.req_rw ? '0 : mem_q[idx];
`else
    assign rsp_prod = req_fire && !bus.req_rw;
    assign rd_dat   = mem_q[idx];
`endif

    always_ff @(posedge clk_i) begin
        if (req_fire && bus.req_rw) begin
            for (int b = 0; b < DATA_SIZE; b++) begin
                if (bus.req_byteen[b]) mem_q[idx][8*b +: 8] <= bus.req_data[8*b +: 8];
            end
        end
    end

    // The FIFO write edge counts as the last pipeline stage, so only LATENCY-1 registers sit in front of it.
    if (LATENCY == 1) begin : g_direct
        assign push_vld = rsp_prod;
        assign push_dat = rd_dat;
        assign push_tag = bus.req_tag;
    end else begin : g_pipe
        localparam int PD = LATENCY - 1;
        logic [PD-1:0]        vld_q;
        logic [DW-1:0]        dat_q [PD];
        logic [TAG_WIDTH-1:0] tag_q [PD];

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                vld_q <= '0;
            end else begin
                vld_q[0] <= rsp_prod;
                for (int i = 1; i < PD; i++) vld_q[i] <= vld_q[i-1];
            end
        end

        always_ff @(posedge clk_i) begin
            dat_q[0] <= rd_dat;
            tag_q[0] <= bus.req_tag;
            for (int i = 1; i < PD; i++) begin
                dat_q[i] <= dat_q[i-1];
                tag_q[i] <= tag_q[i-1];
            end
        end

        assign push_vld = vld_q[PD-1];
        assign push_dat = dat_q[PD-1];
        assign push_tag = tag_q[PD-1];
    end

    always_comb begin
        credits_d = credits_q;
        if (rsp_prod && !rsp_fire)      credits_d = credits_q - CW'(1);
        else if (!rsp_prod && rsp_fire) credits_d = credits_q + CW'(1);
    end

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            credits_q <= CW'(RSP_DEPTH);
            count_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
        end else begin
            credits_q <= credits_d;
            if (push_vld) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (rsp_fire) rd_ptr_q <= ptr_inc(rd_ptr_q);
            if (push_vld && !rsp_fire)      count_q <= count_q + CW'(1);
            else if (!push_vld && rsp_fire) count_q <= count_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_vld) begin
            fifo_dat_q[wr_ptr_q] <= push_dat;
            fifo_tag_q[wr_ptr_q] <= push_tag;
        end
    end

    assign bus.rsp_valid = (count_q != '0);
    assign bus.rsp_data  = fifo_dat_q[rd_ptr_q];
    assign bus.rsp_tag   = fifo_tag_q[rd_ptr_q];

    a_no_fifo_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(push_vld && (count_q == CW'(RSP_DEPTH))));
endmodule

// File: tb/tb_vx_mem_responder.sv
// Directed bench for vx_mem_responder: expected responses are queued at request fire and checked by a monitor.
module tb_vx_mem_responder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    vx_mem_responder_if #(.DATA_SIZE(4), .ADDR_WIDTH(32), .TAG_WIDTH(8)) vif();

    vx_mem_responder #(
        .DATA_SIZE(4), .ADDR_WIDTH(32), .TAG_WIDTH(8),
        .MEM_WORDS(1024), .LATENCY(2), .RSP_DEPTH(4)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (vif.slave)
    );

    typedef struct packed {
        logic [31:0] dat;
        logic [7:0]  tag;
    } rsp_t;

    rsp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    int   pop_cyc [256];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every response handshake pops and compares one scoreboard entry.
    initial begin
        rsp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && vif.rsp_valid && vif.rsp_ready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_rsp: got tag %0h data %0h, expected no response", vif.rsp_tag, vif.rsp_data);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_tag", 64'(vif.rsp_tag), 64'(e.tag));
                    check("rsp_data", 64'(vif.rsp_data), 64'(e.dat));
                    pop_cyc[vif.rsp_tag] = cyc;
                end
            end
        end
    end

    task automatic push_exp(input logic rw, input logic [31:0] exp, input logic [7:0] tag);
`ifdef MEM_RSP_WRITE_ACK_EN
        if (rw) exp_q.push_back('{dat: 32'h0, tag: tag});
        else    exp_q.push_back('{dat: exp, tag: tag});
`else
        if (!rw) exp_q.push_back('{dat: exp, tag: tag});
`endif
    endtask

    task automatic do_req(input logic rw, input logic [3:0] be, input logic [31:0] addr,
                          input logic [31:0] data, input logic [7:0] tag,
                          input logic [31:0] exp, output int fire_cyc);
        vif.req_valid  = 1'b1;
        vif.req_rw     = rw;
        vif.req_byteen = be;
        vif.req_addr   = addr;
        vif.req_data   = data;
        vif.req_tag    = tag;
        fire_cyc = -1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (vif.req_ready) begin
                fire_cyc = cyc;
                break;
            end
        end
        if (fire_cyc < 0) begin
            tests++;
            fails++;
            $display("FAIL req_timeout: got no req_ready in 50 cycles, expected a fire (tag %0h)", tag);
        end else begin
            push_exp(rw, exp, tag);
        end
        @(posedge clk);
        #1;
        vif.req_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0) break;
        end
        check("drain_empty", 64'(exp_q.size()), 64'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Reads of addr 5 with rsp_ready low: exactly RSP_DEPTH fire, then release and watch credits return.
    task automatic bp_test(input logic [7:0] tag_base);
        int nf;
        int f4;
        nf = 0;
        f4 = -1;
        vif.rsp_ready  = 1'b0;
        vif.req_valid  = 1'b1;
        vif.req_rw     = 1'b0;
        vif.req_byteen = 4'h0;
        vif.req_addr   = 32'd5;
        vif.req_data   = 32'h0;
        vif.req_tag    = tag_base;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (nf == 4 && cyc == f4 + 1) check("bp_ready_low_after_4th", 64'(vif.req_ready), 64'd0);
            if (vif.req_ready) begin
                exp_q.push_back('{dat: 32'hCAFE0000, tag: vif.req_tag});
                nf++;
                if (nf == 4) f4 = cyc;
            end
            @(posedge clk);
            #1;
            vif.req_tag = tag_base + 8'(nf);
        end
        vif.req_valid = 1'b0;
        check("bp_fire_count", 64'(nf), 64'd4);
        @(negedge clk);
        check("bp_rsp_valid_held", 64'(vif.rsp_valid), 64'd1);
        @(posedge clk);
        #1;
        vif.rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_ready_at_first_rsp", 64'(vif.req_ready), 64'd0);
        @(negedge clk);
        check("bp_ready_after_first_rsp", 64'(vif.req_ready), 64'd1);
        drain();
    endtask

    initial begin
        int f;
        #200000;
        $display("FAIL global_timeout: got no finish by 200000, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int f;
        vif.req_valid  = 1'b0;
        vif.req_rw     = 1'b0;
        vif.req_byteen = 4'h0;
        vif.req_addr   = 32'h0;
        vif.req_data   = 32'h0;
        vif.req_tag    = 8'h0;
        vif.rsp_ready  = 1'b1;

        @(negedge clk);
        check("reset_req_ready", 64'(vif.req_ready), 64'd0);
        check("reset_rsp_valid", 64'(vif.rsp_valid), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_req_ready", 64'(vif.req_ready), 64'd1);
        @(posedge clk);
        #1;

        // Write then read: response exactly LATENCY cycles after the read fires.
        do_req(1'b1, 4'hF, 32'h10, 32'hDEADBEEF, 8'd3, 32'h0, f);
        do_req(1'b0, 4'h0, 32'h10, 32'h0, 8'd7, 32'hDEADBEEF, f);
        @(negedge clk);
`ifdef MEM_RSP_WRITE_ACK_EN
        check("lat_rsp_valid_n1", 64'(vif.rsp_valid), 64'd1);
`else
        check("lat_rsp_valid_n1", 64'(vif.rsp_valid), 64'd0);
`endif
        @(negedge clk);
        check("lat_cycle", 64'(cyc - f), 64'd2);
        check("lat_rsp_valid_n2", 64'(vif.rsp_valid), 64'd1);
        check("lat_rsp_tag_n2", 64'(vif.rsp_tag), 64'd7);
        drain();

        // Partial byte enables merge with the old word.
        do_req(1'b1, 4'hF, 32'd5, 32'h11223344, 8'd1, 32'h0, f);
        do_req(1'b1, 4'b0101, 32'd5, 32'hAABBCCDD, 8'd2, 32'h0, f);
        do_req(0, 4'h0, 32'd5, 32'h0, 8'd4, 32'h11BB33DD, f);
        drain();

        // Address aliasing and a byteen=0 no-op write.
        do_req(1'b1, 4'hF, 32'd5, 32'hCAFE0000, 8'd5, 32'h0, f);
        do_req(1'b0, 4'h0, 32'h405, 32'h0, 8'd6, 32'hCAFE0000, f);
        do_req(1'b1, 4'h0, 32'd5, 32'hFFFFFFFF, 8'd8, 32'h0, f);
        do_req(1'b0, 4'h0, 32'd5, 32'h0, 8'd11, 32'hCAFE0000, f);
        drain();

        bp_test(8'd0);

        // Reset while reads are in flight: nothing may come out, credits return to full.
        vif.req_valid = 1'b1;
        vif.req_rw    = 1'b0;
        vif.req_addr  = 32'd5;
        vif.req_tag   = 8'd20;
        @(negedge clk);
        check("rst_pre_fire_ready", 64'(vif.req_ready), 64'd1);
        @(posedge clk);
        #1;
        vif.req_tag = 8'd21;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_mid_req_ready", 64'(vif.req_ready), 64'd0);
        check("rst_mid_rsp_valid", 64'(vif.rsp_valid), 64'd0);
        vif.req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("rst_after_req_ready", 64'(vif.req_ready), 64'd1);
        check("rst_after_rsp_valid", 64'(vif.rsp_valid), 64'd0);
        @(posedge clk);
        #1;
        bp_test(8'd40);

`ifdef MEM_RSP_WRITE_ACK_EN
        do_req(1'b1, 4'hF, 32'd7, 32'h00000123, 8'd9, 32'h0, f);
        do_req(1'b0, 4'h0, 32'd7, 32'h0, 8'd10, 32'h00000123, f);
        drain();
        check("ack_consecutive", 64'(pop_cyc[10] - pop_cyc[9]), 64'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
